gate_vector_sequencer: RTL and testbench

// Self-test controller for hex single-input TTL gate models (x74xx04 inverter class).
// It drives every input combination onto the six gate inputs and waits a settle window.
// It then checks the outputs against the expected buffer or inverter function, and counts mismatches.
// It sits between board test logic (start/done handshake) and one gate-model instance in the Gigatron FPGA build.
//

---
 rtl/gate_vector_sequencer_pkg.sv | 16 +
 rtl/gate_vector_sequencer_settle_timer.sv | 37 +++
 rtl/gate_vector_sequencer.sv | 150 +++++++++++++++
 tb/tb_gate_vector_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_vector_sequencer_pkg.sv
// gate_test_pkg: shared types and constants for the gate vector sequencer.
//   gts_state_t - sequencer state encoding (IDLE, APPLY, SETTLE, CHECK, FINISH)
//   ERRCNT_W    - width of the saturating mismatch counter
package gate_test_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    FINISH = 3'd4
  } gts_state_t;

  localparam int ERRCNT_W = 16;

endpackage

// File: rtl/gate_vector_sequencer_settle_timer.sv
// gate_settle_timer: down-counter that times the settle window between
// driving a stimulus vector and sampling the gate outputs.
//   clock_50  in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   load      in   load the counter with load_val
//   load_val  in   TW bits, start value of the countdown
//   expired   out  counter has reached zero
module gate_settle_timer #(
  parameter int  SETTLE_CYCLES = 1,
  localparam int TW            = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic          clock_50,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] count_r;

  // Countdown register: load on request, otherwise decrement and park at zero.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {TW{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (count_r != {TW{1'b0}}) begin
      count_r <= count_r - TW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  // Pure decode of the counter register.
  assign expired = (count_r == {TW{1'b0}});

endmodule

// File: rtl/gate_vector_sequencer.sv
// gate_vector_sequencer: self-test controller for hex single-input gate
// models. Walks every input combination onto stim, waits a settle window,
// compares resp against the expected inverter/buffer function and records
// mismatches.
//   clock_50       in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   request a run (honoured only in IDLE)
//   abort          in   cancel a run in progress
//   stim           out  WIDTH  gate inputs, bit0 = A1
//   resp           in   WIDTH  gate outputs, bit0 = Y1
//   busy           out  run in progress
//   done           out  one-cycle pulse at run completion
//   pass           out  last completed run had zero mismatches
//   error_count    out  16  saturating count of mismatching vectors
//   fail_mask      out  WIDTH  sticky OR of mismatching bit positions
//   first_fail_vec out  WIDTH  stim of the first mismatching vector
module gate_vector_sequencer
  import gate_test_pkg::*;
#(
  parameter int WIDTH         = 6,
  parameter int SETTLE_CYCLES = 1,
  parameter bit INVERT        = 1'b1
) (
  input  logic                clock_50,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  output logic [WIDTH-1:0]    stim,
  input  logic [WIDTH-1:0]    resp,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERRCNT_W-1:0] error_count,
  output logic [WIDTH-1:0]    fail_mask,
  output logic [WIDTH-1:0]    first_fail_vec
);

  localparam int TW = $clog2(SETTLE_CYCLES + 1);
  // One extra bit so the terminal compare never relies on wrap-around.
  localparam logic [WIDTH:0] VEC_LAST = (WIDTH + 1)'((1 << WIDTH) - 1);
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = {ERRCNT_W{1'b1}};

  gts_state_t       state_r;
  logic [WIDTH:0]   vec_r;
  logic [WIDTH-1:0] exp_s;
  logic [WIDTH-1:0] mism_bits_s;
  logic             mismatch_s;
  logic             timer_load_s;
  logic             timer_expired_s;
  logic [TW-1:0]    timer_load_val_s;

  assign timer_load_val_s = TW'(SETTLE_CYCLES - 1);

  // Expected response and per-bit mismatch for the vector currently on stim.
  always_comb begin
    exp_s        = INVERT ? ~stim : stim;
    mism_bits_s  = resp ^ exp_s;
    mismatch_s   = |mism_bits_s;
    timer_load_s = (state_r == APPLY);
  end

  gate_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clock_50(clock_50),
    .reset_n (reset_n),
    .load    (timer_load_s),
    .load_val(timer_load_val_s),
    .expired (timer_expired_s)
  );

  // Sequencer FSM with all result outputs registered.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      vec_r          <= {(WIDTH + 1){1'b0}};
      stim           <= {WIDTH{1'b0}};
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      error_count    <= {ERRCNT_W{1'b0}};
      fail_mask      <= {WIDTH{1'b0}};
      first_fail_vec <= {WIDTH{1'b0}};
    end else if (abort && (state_r != IDLE)) begin
      // Abort wins over any CHECK update; partial counts are kept.
      state_r <= IDLE;
      stim    <= {WIDTH{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          stim <= {WIDTH{1'b0}};
          if (start) begin
            error_count    <= {ERRCNT_W{1'b0}};
            fail_mask      <= {WIDTH{1'b0}};
            first_fail_vec <= {WIDTH{1'b0}};
            vec_r          <= {(WIDTH + 1){1'b0}};
            busy           <= 1'b1;
            state_r        <= APPLY;
          end
        end
        APPLY: begin
          stim    <= vec_r[WIDTH-1:0];
          state_r <= SETTLE;
        end
        SETTLE: begin
          if (timer_expired_s) begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (mismatch_s) begin
            if (error_count != ERRCNT_MAX) begin
              error_count <= error_count + ERRCNT_W'(1);
            end
            fail_mask <= fail_mask | mism_bits_s;
            // Counter is still zero only before the first mismatch of the run.
            if (error_count == {ERRCNT_W{1'b0}}) begin
              first_fail_vec <= stim;
            end
          end
          if (vec_r == VEC_LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (error_count == {ERRCNT_W{1'b0}}) && !mismatch_s;
            state_r <= FINISH;
          end else begin
            vec_r   <= vec_r + (WIDTH + 1)'(1);
            state_r <= APPLY;
          end
        end
        FINISH: begin
          done    <= 1'b0;
          stim    <= {WIDTH{1'b0}};
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          stim    <= {WIDTH{1'b0}};
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_sequencer.sv
module tb_gate_vector_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_v [3];
  logic        abort_v [3];
  logic [5:0]  stim_v  [3];
  logic [5:0]  resp_v  [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        pass_v  [3];
  logic [15:0] ec_v    [3];
  logic [5:0]  fm_v    [3];
  logic [5:0]  ff_v    [3];

  int tests_run = 0;
  int tests_failed = 0;
  int mode = 0;          // dut0 gate model: 0 inverter, 1 Y3 stuck low, 2 inverter delayed 2 clks
  int done_cnt [3];
  logic [5:0] d0a = 6'h3F, d0b = 6'h3F, d2a = 6'h3F, d2b = 6'h3F;

  always #10 clk = ~clk;

  // Two-clock delayed inverter models.
  always @(posedge clk) begin
    d0a <= ~stim_v[0];
    d0b <= d0a;
    d2a <= ~stim_v[2];
    d2b <= d2a;
  end

  always_comb begin
    resp_v[0] = ~stim_v[0];
    if (mode == 1) resp_v[0] = ~stim_v[0] & 6'b111011;
    else if (mode == 2) resp_v[0] = d0b;
    resp_v[1] = ~stim_v[1];
    resp_v[2] = d2b;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (done_v[k]) done_cnt[k] = done_cnt[k] + 1;
  end

  gate_vector_sequencer dut0 (
    .clock_50(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]),
    .stim(stim_v[0]), .resp(resp_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .error_count(ec_v[0]), .fail_mask(fm_v[0]), .first_fail_vec(ff_v[0]));

  gate_vector_sequencer #(.INVERT(1'b0)) dut1 (
    .clock_50(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]),
    .stim(stim_v[1]), .resp(resp_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .error_count(ec_v[1]), .fail_mask(fm_v[1]), .first_fail_vec(ff_v[1]));

  gate_vector_sequencer #(.SETTLE_CYCLES(3)) dut2 (
    .clock_50(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]),
    .stim(stim_v[2]), .resp(resp_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .error_count(ec_v[2]), .fail_mask(fm_v[2]), .first_fail_vec(ff_v[2]));

  // Pulse start for one clock and count the cycles busy stays high (bounded).
  task automatic run_dut(input int k, output int cycles, output logic done_seen);
    @(negedge clk) start_v[k] = 1'b1;
    @(negedge clk) start_v[k] = 1'b0;
    cycles = 0;
    while (busy_v[k] && cycles < 1000) begin
      cycles++;
      @(negedge clk);
    end
    done_seen = done_v[k];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({stim_v[k], busy_v[k], done_v[k], pass_v[k], ec_v[k], fm_v[k], ff_v[k]} !== 37'd0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got stim=%h busy=%b done=%b pass=%b ec=%0d fm=%h ff=%h, want all 0",
                 k, stim_v[k], busy_v[k], done_v[k], pass_v[k], ec_v[k], fm_v[k], ff_v[k]);
      end
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean();
    int cyc; logic dn;
    mode = 0;
    run_dut(0, cyc, dn);
    tests_run++;
    if (cyc !== 192) begin tests_failed++; $display("FAIL clean_busy_len: got %0d want 192", cyc); end
    tests_run++;
    if (dn !== 1'b1) begin tests_failed++; $display("FAIL clean_done: got %b want 1", dn); end
    tests_run++;
    if ({pass_v[0], ec_v[0], fm_v[0]} !== {1'b1, 16'd0, 6'h00}) begin
      tests_failed++;
      $display("FAIL clean_result: got pass=%b ec=%0d fm=%h want pass=1 ec=0 fm=00", pass_v[0], ec_v[0], fm_v[0]);
    end
    @(negedge clk);
    tests_run++;
    if ({done_v[0], stim_v[0]} !== {1'b0, 6'h00}) begin
      tests_failed++;
      $display("FAIL clean_after: got done=%b stim=%h want done=0 stim=00", done_v[0], stim_v[0]);
    end
  endtask

  task automatic test_stuck_y3();
    int cyc; logic dn;
    mode = 1;
    run_dut(0, cyc, dn);
    tests_run++;
    if ({dn, pass_v[0], ec_v[0], fm_v[0], ff_v[0]} !== {1'b1, 1'b0, 16'd32, 6'b000100, 6'h00}) begin
      tests_failed++;
      $display("FAIL stuck_y3: got done=%b pass=%b ec=%0d fm=%h ff=%h want done=1 pass=0 ec=32 fm=04 ff=00",
               dn, pass_v[0], ec_v[0], fm_v[0], ff_v[0]);
    end
    mode = 0;
  endtask

  task automatic test_buffer_mode();
    int cyc; logic dn;
    run_dut(1, cyc, dn);
    tests_run++;
    if ({cyc, dn, pass_v[1], ec_v[1], fm_v[1], ff_v[1]} !== {32'd192, 1'b1, 1'b0, 16'd64, 6'h3F, 6'h00}) begin
      tests_failed++;
      $display("FAIL buffer_mode: got cyc=%0d done=%b pass=%b ec=%0d fm=%h ff=%h want 192 1 0 64 3f 00",
               cyc, dn, pass_v[1], ec_v[1], fm_v[1], ff_v[1]);
    end
  endtask

  task automatic test_settle();
    int cyc; logic dn;
    run_dut(2, cyc, dn);
    tests_run++;
    if (cyc !== 320) begin tests_failed++; $display("FAIL settle3_len: got %0d want 320", cyc); end
    tests_run++;
    if ({dn, pass_v[2], ec_v[2]} !== {1'b1, 1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL settle3_result: got done=%b pass=%b ec=%0d want 1 1 0", dn, pass_v[2], ec_v[2]);
    end
    // Settle of 1 against the delayed model sees the previous vector's output.
    mode = 2;
    run_dut(0, cyc, dn);
    tests_run++;
    if ({pass_v[0], ec_v[0], fm_v[0], ff_v[0]} !== {1'b0, 16'd63, 6'h3F, 6'h01}) begin
      tests_failed++;
      $display("FAIL settle1_delayed: got pass=%b ec=%0d fm=%h ff=%h want 0 63 3f 01",
               pass_v[0], ec_v[0], fm_v[0], ff_v[0]);
    end
    mode = 0;
  endtask

  task automatic test_abort();
    int cyc; logic dn; int dc;
    mode = 0;
    run_dut(0, cyc, dn);
    tests_run++;
    if (pass_v[0] !== 1'b1) begin tests_failed++; $display("FAIL abort_pre_pass: got %b want 1", pass_v[0]); end
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (49) @(negedge clk);
    dc = done_cnt[0];
    abort_v[0] = 1'b1;
    @(negedge clk) abort_v[0] = 1'b0;
    tests_run++;
    if ({busy_v[0], stim_v[0], pass_v[0]} !== {1'b0, 6'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_state: got busy=%b stim=%h pass=%b want 0 00 0", busy_v[0], stim_v[0], pass_v[0]);
    end
    repeat (10) @(negedge clk);
    tests_run++;
    if (done_cnt[0] !== dc) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt[0] - dc); end
    run_dut(0, cyc, dn);
    tests_run++;
    if ({cyc, dn, pass_v[0], ec_v[0]} !== {32'd192, 1'b1, 1'b1, 16'd0}) begin
      tests_failed++;
      $display("FAIL abort_rerun: got cyc=%0d done=%b pass=%b ec=%0d want 192 1 1 0", cyc, dn, pass_v[0], ec_v[0]);
    end
  endtask

  task automatic test_start_busy_reset();
    int cyc; int dc;
    mode = 0;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    cyc = 0;
    while (busy_v[0] && cyc < 1000) begin
      cyc++;
      start_v[0] = (cyc == 20);
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    tests_run++;
    if ({cyc, pass_v[0]} !== {32'd192, 1'b1}) begin
      tests_failed++;
      $display("FAIL start_while_busy: got cyc=%0d pass=%b want 192 1", cyc, pass_v[0]);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy_v[0] !== 1'b0) begin tests_failed++; $display("FAIL start_while_busy_idle: got busy=%b want 0", busy_v[0]); end
    // Reset mid-run with errors already recorded.
    mode = 1;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (30) @(negedge clk);
    #5 reset_n = 1'b0;
    dc = done_cnt[0];
    #1;
    tests_run++;
    if ({stim_v[0], busy_v[0], done_v[0], pass_v[0], ec_v[0], fm_v[0], ff_v[0]} !== 37'd0) begin
      tests_failed++;
      $display("FAIL midrun_reset: got stim=%h busy=%b done=%b pass=%b ec=%0d fm=%h ff=%h want all 0",
               stim_v[0], busy_v[0], done_v[0], pass_v[0], ec_v[0], fm_v[0], ff_v[0]);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mode = 0;
    repeat (20) @(negedge clk);
    tests_run++;
    if ({done_cnt[0] - dc, busy_v[0]} !== {32'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrun_reset_quiet: got done pulses=%0d busy=%b want 0 0", done_cnt[0] - dc, busy_v[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      abort_v[k] = 1'b0;
      done_cnt[k] = 0;
    end
    test_reset();
    test_clean();
    test_stuck_y3();
    test_buffer_mode();
    test_settle();
    test_abort();
    test_start_busy_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
